// File: rtl/instr_mem_loader.sv
// Byte-stream loader for instruction memory: parses length/words/checksum, writes words, releases the CPU on success.
// Optional idle timeout enabled by defining LOADER_TIMEOUT_EN.
module instr_mem_loader #(
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int          MAX_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reload,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state;
  logic [15:0] len;
  logic [15:0] index;
  logic [7:0]  hi;
  logic [7:0]  acc;
  logic        accept;
  logic        timed_out;
  logic [15:0] len_full;

  // reload gates the handshake so a byte presented with it is never taken
  assign in_ready = (state != S_DONE) && (state != S_ERR) && !reload;
  assign accept   = in_valid && in_ready;
  assign len_full = {len[15:8], in_data};

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          counting;

  assign counting  = (state == S_LEN_LO) || (state == S_DAT_HI) ||
                     (state == S_DAT_LO) || (state == S_CHK);
  assign timed_out = counting && !accept && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset || reload || accept || !counting) idle_cnt <= '0;
    else                                         idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_LEN_HI;
      len        <= '0;
      index      <= '0;
      hi         <= '0;
      acc        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        state    <= S_LEN_HI;
        index    <= '0;
        acc      <= '0;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        error    <= 1'b0;
      end else if (timed_out) begin
        state <= S_ERR;
        error <= 1'b1;
      end else if (accept) begin
        case (state)
          S_LEN_HI: begin
            len[15:8] <= in_data;
            state     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len[7:0] <= in_data;
            if (len_full == 16'd0) state <= S_CHK;
            else if ({1'b0, len_full} > MAX_N) begin
              state <= S_ERR;
              error <= 1'b1;
            end else state <= S_DAT_HI;
          end
          S_DAT_HI: begin
            hi    <= in_data;
            acc   <= acc ^ in_data;
            state <= S_DAT_LO;
          end
          S_DAT_LO: begin
            imem_we    <= 1'b1;
            imem_addr  <= BASE_ADDR + index;
            imem_wdata <= {hi, in_data};
            acc        <= acc ^ in_data;
            index      <= index + 16'd1;
            state      <= ((index + 16'd1) == len) ? S_CHK : S_DAT_HI;
          end
          S_CHK: begin
            if (in_data == acc) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table of streams plus hand sequences for reload, reset and timeout.
module tb_instr_mem_loader;
  logic        clk = 1'b0;
  logic        reset, reload, in_valid;
  logic [7:0]  in_data;
  logic        in_ready0, imem_we0, cpu_hold0, done0, error0;
  logic        in_ready1, imem_we1, cpu_hold1, done1, error1;
  logic [15:0] imem_addr0, imem_wdata0, imem_addr1, imem_wdata1;

  instr_mem_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256), .TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .reset(reset), .reload(reload), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .imem_we(imem_we0), .imem_addr(imem_addr0), .imem_wdata(imem_wdata0),
    .cpu_hold(cpu_hold0), .done(done0), .error(error0));

  instr_mem_loader #(.BASE_ADDR(16'h0100), .MAX_WORDS(256), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .reset(reset), .reload(reload), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_wdata(imem_wdata1),
    .cpu_hold(cpu_hold1), .done(done1), .error(error1));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [15:0] data; int due; } wr_t;
  typedef struct { logic [7:0] b [0:11]; int n; int gap; logic exp_done; logic exp_err; } vec_t;

  wr_t  sb[$];
  wr_t  e;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the oldest expected word, in the expected cycle.
  always @(negedge clk) begin
    if (imem_we0 || imem_we1) begin
      if (sb.size() == 0) chk("unexpected_write", 32'(imem_we0 | imem_we1), 0);
      else begin
        e = sb.pop_front();
        chk("we_both", {imem_we0, imem_we1}, 2'b11);
        chk("addr0", imem_addr0, e.idx[15:0]);
        chk("addr1", imem_addr1, 16'h0100 + e.idx[15:0]);
        chk("wdata0", imem_wdata0, e.data);
        chk("wdata1", imem_wdata1, e.data);
        chk("write_latency", cyc, e.due);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
    repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    chk("in_ready_loading", {in_ready0, in_ready1}, 2'b11);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic run_stream(input vec_t v, output int nwr, output int lidx, output logic [15:0] ldat);
    int nw, c, gap;
    wr_t w;
    nw = int'({v.b[0], v.b[1]});
    nwr = 0; lidx = 0; ldat = '0;
    for (int j = 0; j < v.n; j++) begin
      gap = (v.gap > 0) ? int'($urandom_range(v.gap, 0)) : 0;
      send_byte(v.b[j], gap, c);
      if (j >= 3 && nw <= 256 && j < 2 + 2 * nw && ((j - 2) % 2) == 1) begin
        w.idx = (j - 3) / 2; w.data = {v.b[j-1], v.b[j]}; w.due = c;
        sb.push_back(w);
        nwr++; lidx = w.idx; ldat = w.data;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1; in_valid = 1'b0;
    #1;
    chk("in_ready_during_reload", {in_ready0, in_ready1}, 2'b00);
    @(negedge clk);
    reload = 1'b0;
    chk("post_reload_flags", {done0, error0, cpu_hold0}, 3'b001);
  endtask

  initial begin
    int nwr, lidx, c;
    logic [15:0] ldat;
    vec_t v;
    vt[0] = '{'{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 7, 0, 1'b1, 1'b0};
    vt[1] = '{'{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 7, 0, 1'b0, 1'b1};
    vt[2] = '{'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 1'b1, 1'b0};
    vt[3] = '{'{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 0, 1'b0, 1'b1};
    vt[4] = '{'{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 7, 5, 1'b1, 1'b0};
    vt[5] = '{'{8'h00, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h80, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00}, 9, 2, 1'b1, 1'b0};
    vt[6] = '{'{8'h00, 8'h01, 8'h5A, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 0, 1'b1, 1'b0};

    reset = 1'b0; reload = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_we", imem_we0, 0);
    chk("reset_addr0", imem_addr0, 16'h0000);
    chk("reset_addr1", imem_addr1, 16'h0100);
    chk("reset_wdata", imem_wdata0, 0);
    chk("reset_flags", {cpu_hold0, done0, error0, in_ready0}, 4'b1001);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_reload();
      run_stream(vt[i], nwr, lidx, ldat);
      chk($sformatf("v%0d_done_err", i), {done0, error0, done1, error1},
          {vt[i].exp_done, vt[i].exp_err, vt[i].exp_done, vt[i].exp_err});
      chk($sformatf("v%0d_cpu_hold", i), cpu_hold0, !vt[i].exp_done);
      chk($sformatf("v%0d_in_ready", i), {in_ready0, in_ready1}, 2'b00);
      chk($sformatf("v%0d_pending", i), sb.size(), 0);
      if (nwr > 0) begin
        chk($sformatf("v%0d_addr_hold", i), imem_addr0, lidx[15:0]);
        chk($sformatf("v%0d_data_hold", i), imem_wdata0, ldat);
      end
    end

    // Largest legal length must not be rejected.
    do_reload();
    send_byte(8'h01, 0, c);
    send_byte(8'h00, 0, c);
    @(negedge clk); in_valid = 1'b0; #1;
    chk("n256_accepted", {error0, in_ready0}, 2'b01);

    // Reload together with the next byte: that byte is dropped and loading restarts.
    do_reload();
    v = vt[0]; v.n = 5;
    run_stream(v, nwr, lidx, ldat);
    @(negedge clk);
    reload = 1'b1; in_valid = 1'b1; in_data = 8'hCD;
    #1;
    chk("reload_blocks_byte", in_ready0, 0);
    @(negedge clk);
    reload = 1'b0; in_valid = 1'b0;
    chk("reload_no_write", {imem_we0, done0, error0, cpu_hold0}, 4'b0001);
    run_stream(vt[0], nwr, lidx, ldat);
    chk("reload_reload_done", {done0, error0, cpu_hold0}, 3'b100);

    // Reset on the same edge as a low byte suppresses the pending write.
    do_reload();
    v = vt[0]; v.n = 3;
    run_stream(v, nwr, lidx, ldat);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h34; reset = 1'b0;
    @(negedge clk);
    chk("midreset_we", {imem_we0, imem_we1}, 2'b00);
    chk("midreset_addr", {imem_addr0, imem_addr1}, {16'h0000, 16'h0100});
    chk("midreset_wdata", imem_wdata0, 0);
    chk("midreset_flags", {cpu_hold0, done0, error0, in_ready0}, 4'b1001);
    reset = 1'b1; in_valid = 1'b0;

    // Waiting for the first length byte never errors.
    repeat (40) @(negedge clk);
    chk("len_hi_no_timeout", {error0, in_ready0}, 2'b01);

    do_reload();
    send_byte(8'h00, 0, c);
    @(negedge clk); in_valid = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 15) chk("timeout_not_early", error0, 0);
    end
    chk("timeout_error", {error0, done0, cpu_hold0, in_ready0}, 4'b1010);
`else
    repeat (2000) @(posedge clk);
    #1;
    chk("no_timeout", {error0, done0, cpu_hold0, in_ready0}, 4'b0011);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction-memory interface. The 16-bit datapath only reads instruction memory (PC address in, instruction out); this block fills it.
- Accepts a byte stream with a valid/ready handshake, assembles 16-bit instruction words, and issues write pulses to instruction memory.
- Keeps the datapath held in reset until a complete, checksum-verified program has been loaded.

Parameters:
- BASE_ADDR, 16'h0000, instruction-memory address of the first loaded word.
- MAX_WORDS, 256, largest program length accepted; anything longer is rejected.
- TIMEOUT_CYCLES, 1024, idle-cycle limit, used only when LOADER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- reload  input  1  one-cycle pulse; restarts loading.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte; a byte is accepted when in_valid && in_ready.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  16  write address.
- imem_wdata  output  16  write data.
- cpu_hold  output  1  drives the datapath reset; 1 = CPU held.
- done  output  1  program loaded and checksum good.
- error  output  1  load failed.

Behaviour:
- Stream format:
  - LEN_HI, LEN_LO: 16-bit word count N, high byte first.
  - N words, each sent as high byte then low byte.
  - One checksum byte: XOR of all 2N data bytes. Length bytes are excluded.
- Reset (reset==0 at a clock edge):
  - State goes to S_LEN_HI; word index, checksum accumulator and timeout counter clear to 0.
  - Outputs: imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, done=0, error=0.
- States: S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK, S_DONE, S_ERR.
- in_ready is 1 in S_LEN_HI through S_CHK and 0 in S_DONE/S_ERR. It is forced to 0 in any cycle where reload==1 (combinational gating).
- Transitions, each taken only on an accepted byte:
  - S_LEN_HI -> S_LEN_LO.
  - S_LEN_LO: if N==0, go to S_CHK. If N>MAX_WORDS, go to S_ERR. Otherwise go to S_DAT_HI.
  - S_DAT_HI -> S_DAT_LO.
  - S_DAT_LO: the next cycle drives imem_we=1, imem_addr=BASE_ADDR+index (16-bit wrap), imem_wdata={hi,lo}. The index then increments. Go to S_CHK if index+1==N, else S_DAT_HI.
  - S_CHK: if the byte equals the accumulator, go to S_DONE, else S_ERR.
- Write latency: exactly 1 cycle from acceptance of the low byte to the imem_we pulse. All write outputs are registered. imem_addr/imem_wdata hold their last value when imem_we=0.
- Back-to-back bytes (in_valid held 1) are accepted every cycle; there are no bubbles in the handshake.
- S_DONE: done=1, cpu_hold=0, error=0.
- S_ERR: error=1, done=0, cpu_hold=1.
- Both S_DONE and S_ERR are left only via reload or reset.
- reload (any state): next state is S_LEN_HI; index and accumulator clear; done=0, error=0, cpu_hold=1. Memory already written is not erased.
- reload and in_valid in the same cycle: reload wins and the byte is not accepted.
- Reset mid-load: same as the reset values above. A pending imem_we pulse is suppressed.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - In S_LEN_LO through S_CHK, a counter increments on every cycle with no accepted byte and clears on acceptance.
  - When the counter reaches TIMEOUT_CYCLES, the block goes to S_ERR.
  - S_LEN_HI never times out.
- Not defined: no counter exists, and the loader waits indefinitely for the next byte.

Test Plan:
- Normal load: reset low 2 cycles; stream 00 02 12 34 AB CD then checksum 12^34^AB^CD=40, in_valid held high -> imem_we pulses at addr 0000 data 1234 and at addr 0001 data ABCD, each 1 cycle after the low byte; then done=1, cpu_hold=0, error=0.
- Bad checksum: same stream with checksum 41 -> both writes still occur; error=1, done=0, cpu_hold=1, in_ready=0.
- Length limits: N=0000 followed by checksum 00 -> done=1 with no imem_we. N=0101 with MAX_WORDS=256 -> error=1 right after LEN_LO; in_ready=0.
- Handshake gaps: bytes with random in_valid gaps of 0-5 cycles, and BASE_ADDR=16'h0100 -> writes land at 0100, 0101 with correct data. Confirm no byte is accepted while in_ready=0.
- Reload/reset mid-load: reload pulsed after the DAT_HI byte of word 1, together with in_valid -> that byte is dropped; a new full stream loads from BASE_ADDR. Reset low mid-stream -> all outputs return to their reset values.
- Timeout: with LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, stall after LEN_HI -> error=1 after 16 idle cycles. Without the macro -> no error after 2000 idle cycles.
